// File: rtl/riscv_pkg.sv
// Shared constants and the write-buffer entry type used by the data-memory
// responder and its write buffer.
package riscv_pkg;
  localparam int XLEN            = 32;
  localparam int DEPTH_WORDS_DEF = 64;
  localparam int WBUF_DEPTH_DEF  = 4;
  // Word index field is sized for the largest possible word address so the
  // entry type does not depend on the memory-size parameter.
  localparam int WBUF_IDX_W      = XLEN - 2;

  typedef struct packed {
    logic [WBUF_IDX_W-1:0] index;
    logic [XLEN-1:0]       data;
  } wbuf_entry_t;
endpackage

// File: rtl/dmem_wbuf.sv
// Circular write-buffer FIFO. Besides push/pop it exposes every slot in
// age order (entry 0 = oldest) with a valid bit, so the owner can do
// address matching and pick the youngest hit by scanning upward.
module dmem_wbuf
  import riscv_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH_DEF,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  wbuf_entry_t             push_entry,
  input  logic                    pop,
  output wbuf_entry_t             head_entry,
  output logic                    full,
  output logic                    empty,
  output logic [PW:0]             count,
  output wbuf_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]        valid
);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

  wbuf_entry_t [DEPTH-1:0] slot_r;
  logic [PW-1:0]           head_r;
  logic [PW-1:0]           tail_r;
  logic [PW:0]             count_r;
  logic                    full_s;
  logic                    empty_s;
  logic                    push_ok_s;
  logic                    pop_ok_s;

  assign full_s    = (count_r == CNT_MAX);
  assign empty_s   = (count_r == '0);
  assign push_ok_s = push && !full_s;
  assign pop_ok_s  = pop && !empty_s;

  // Pointer, occupancy and slot storage update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      slot_r  <= '0;
    end else begin
      if (push_ok_s) begin
        slot_r[tail_r] <= push_entry;
        tail_r         <= tail_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Age-ordered view of the occupied slots for address matching
  always_comb begin
    entries = '0;
    valid   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      entries[k] = slot_r[head_r + PW'(k)];
      valid[k]   = ((PW+1)'(k) < count_r);
    end
  end

  assign head_entry = slot_r[head_r];
  assign full       = full_s;
  assign empty      = empty_s;
  assign count      = count_r;
endmodule

// File: rtl/dmem_wbuf_responder.sv
// Data memory with a write buffer in front of a single-port array.
// Stores are queued and drained one per idle cycle; loads have priority
// over draining. Optional macro DMEM_WBUF_FWD_EN compiles in load
// forwarding from the youngest matching buffered store; without it a load
// that hits a buffered store stalls while the buffer drains.
module dmem_wbuf_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int WBUF_DEPTH  = WBUF_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(WBUF_DEPTH) + 1;

  logic [31:0]                  mem_r [DEPTH_WORDS];
  logic [31:0]                  read_data_r;
  logic [AW-1:0]                idx_s;
  logic [WBUF_IDX_W-1:0]        idx_ext_s;
  wbuf_entry_t                  push_entry_s;
  wbuf_entry_t                  head_entry_s;
  wbuf_entry_t [WBUF_DEPTH-1:0] entries_s;
  logic [WBUF_DEPTH-1:0]        valid_s;
  logic [WBUF_DEPTH-1:0]        match_s;
  logic [CW-1:0]                count_s;
  logic                         full_s;
  logic                         empty_s;
  logic                         match_stall_s;
  logic                         stall_s;
  logic                         push_s;
  logic                         read_go_s;
  logic                         drain_s;
  logic [31:0]                  load_data_s;
  logic                         unused_s;

  assign idx_s        = DataAdr[AW+1:2];
  assign idx_ext_s    = WBUF_IDX_W'(idx_s);
  assign push_entry_s = '{index: idx_ext_s, data: WriteData};

  dmem_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk        (clk),
    .reset      (reset),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (drain_s),
    .head_entry (head_entry_s),
    .full       (full_s),
    .empty      (empty_s),
    .count      (count_s),
    .entries    (entries_s),
    .valid      (valid_s)
  );

  // Per-entry address match against the requested word
  always_comb begin
    match_s = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      match_s[k] = valid_s[k] && (entries_s[k].index == idx_ext_s);
    end
  end

`ifdef DMEM_WBUF_FWD_EN
  logic        fwd_hit_s;
  logic [31:0] fwd_data_s;

  // Youngest matching entry wins: later (younger) hits overwrite earlier ones
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = 32'h0000_0000;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      fwd_hit_s  = fwd_hit_s | match_s[k];
      fwd_data_s = match_s[k] ? entries_s[k].data : fwd_data_s;
    end
  end

  assign match_stall_s = 1'b0;
  assign load_data_s   = fwd_hit_s ? fwd_data_s : mem_r[idx_s];
  assign unused_s      = ^{DataAdr[31:AW+2], DataAdr[1:0],
                           head_entry_s.index[WBUF_IDX_W-1:AW], count_s};
`else
  // Without forwarding a load must wait until its word has left the buffer
  assign match_stall_s = MemRead && (|match_s);
  assign load_data_s   = mem_r[idx_s];
  assign unused_s      = ^{DataAdr[31:AW+2], DataAdr[1:0],
                           head_entry_s.index[WBUF_IDX_W-1:AW], count_s,
                           entries_s};
`endif

  // A full buffer blocks stores even if a drain frees a slot this same edge
  assign stall_s   = (MemWrite && full_s) || match_stall_s;
  assign push_s    = MemWrite && !stall_s;
  assign read_go_s = MemRead && !stall_s;
  // The array port goes to the load unless the load itself is stalled on a hit
  assign drain_s   = !empty_s && (!MemRead || match_stall_s);

  // Array write port: retire the oldest buffered store; contents survive reset
  always_ff @(posedge clk) begin
    if (drain_s) begin
      mem_r[head_entry_s.index[AW-1:0]] <= head_entry_s.data;
    end
  end

  // Load result register, updated only by an accepted load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data_r <= 32'h0000_0000;
    end else if (read_go_s) begin
      read_data_r <= load_data_s;
    end
  end

  assign ReadData = read_data_r;
  assign Stall    = stall_s;
endmodule

// File: tb/tb_dmem_wbuf_responder.sv
// Self-checking bench for dmem_wbuf_responder: a queue-plus-array model of
// the buffered memory, directed scenarios, then randomized traffic with
// occasional mid-run resets. Honours DMEM_WBUF_FWD_EN like the design.
module tb_dmem_wbuf_responder;
  localparam int DW = 64;
  localparam int WD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mem_m [DW];
  logic [31:0] rd_m;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dmem_wbuf_responder #(.DEPTH_WORDS(DW), .WBUF_DEPTH(WD)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % DW);
  endfunction

  // One clock of traffic: predict Stall before the edge, update the model
  // across the edge, then compare ReadData.
  task automatic step(input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d, output logic st);
    bit          full, match, mstall, stall_m, read_go, drain;
    logic [31:0] rv;
    int          ix;
    MemWrite  = w;
    MemRead   = r;
    DataAdr   = a;
    WriteData = d;
    #2;
    ix    = widx(a);
    full  = (q.size() == WD);
    match = 1'b0;
    rv    = mem_m[ix];
    foreach (q[i]) begin
      if (q[i].idx == ix) begin
        match = 1'b1;
`ifdef DMEM_WBUF_FWD_EN
        rv = q[i].data;
`endif
      end
    end
`ifdef DMEM_WBUF_FWD_EN
    mstall = 1'b0;
`else
    mstall = r && match;
`endif
    stall_m = (w && full) || mstall;
    read_go = r && !stall_m;
    drain   = (q.size() > 0) && (!r || mstall);
    chk("stall", {31'b0, Stall}, {31'b0, stall_m});
    st = Stall;
    @(posedge clk);
    #1;
    if (read_go) rd_m = rv;
    if (drain) begin
      mem_m[q[0].idx] = q[0].data;
      void'(q.pop_front());
    end
    if (w && !stall_m) q.push_back('{idx: ix, data: d});
    chk("readdata", ReadData, rd_m);
  endtask

  task automatic idle(input int n);
    logic st;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, st);
  endtask

  // Hold a load until accepted (bounded), return the loaded value
  task automatic load_wait(input logic [31:0] a, output logic [31:0] d);
    logic st;
    int   n;
    st = 1'b1;
    n  = 0;
    while (st && n < 30) begin
      step(1'b0, 1'b1, a, 32'h0, st);
      n++;
    end
    chk("load_accept", {31'b0, st}, 32'h0);
    d = ReadData;
  endtask

  task automatic do_reset();
    MemWrite = 1'b1;
    MemRead  = 1'b1;
    DataAdr  = $urandom;
    reset    = 1'b1;
    #2;
    chk("rst_readdata", ReadData, 32'h0);
    chk("rst_stall", {31'b0, Stall}, 32'h0);
    q.delete();
    rd_m = 32'h0;
    @(posedge clk);
    #1;
    chk("rst_readdata_hold", ReadData, 32'h0);
    reset    = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    chk("rst_count", 32'(u_dut.u_wbuf.count), 32'h0);
  endtask

  initial begin
    logic        st;
    logic [31:0] d;
    logic [31:0] a;
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; DataAdr = 32'h0; WriteData = 32'h0;
    rd_m = 32'h0;
    @(posedge clk);
    #1;
    chk("init_readdata", ReadData, 32'h0);
    chk("init_stall", {31'b0, Stall}, 32'h0);
    reset = 1'b0;

    // Give every array word a known value
    for (int i = 0; i < DW; i++) step(1'b1, 1'b0, 32'(i * 4), 32'hA000_0000 + 32'(i), st);
    idle(WD + 1);

    // Store then load after an idle cycle
    step(1'b1, 1'b0, 32'd100, 32'd25, st);
    idle(1);
    load_wait(32'd100, d);
    chk("store_load_100", d, 32'd25);

`ifdef DMEM_WBUF_FWD_EN
    // Back-to-back store/load forwarded without a stall
    step(1'b1, 1'b0, 32'd96, 32'd7, st);
    step(1'b0, 1'b1, 32'd96, 32'h0, st);
    chk("fwd_no_stall", {31'b0, st}, 32'h0);
    chk("fwd_data_96", ReadData, 32'd7);
`else
    // Back-to-back store/load stalls until the store drains
    idle(WD + 1);
    step(1'b1, 1'b0, 32'd8, 32'd9, st);
    step(1'b0, 1'b1, 32'd8, 32'h0, st);
    chk("nofwd_stall", {31'b0, st}, 32'h1);
    load_wait(32'd8, d);
    chk("nofwd_data_8", d, 32'd9);
`endif

    // Fill the buffer while loads block draining
    idle(WD + 1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 32'(i * 4), 32'd100 + 32'(i), st);
      chk("fill_no_stall", {31'b0, st}, 32'h0);
    end
    step(1'b1, 1'b1, 32'd16, 32'd104, st);
    chk("full_stall", {31'b0, st}, 32'h1);
    step(1'b1, 1'b0, 32'd16, 32'd104, st);
    chk("full_stall_drain_edge", {31'b0, st}, 32'h1);
    step(1'b1, 1'b0, 32'd16, 32'd104, st);
    chk("full_stall_cleared", {31'b0, st}, 32'h0);

    // Repeated stores to one word: last one wins
    idle(WD + 1);
    step(1'b1, 1'b0, 32'd40, 32'd1, st);
    step(1'b1, 1'b0, 32'd40, 32'd2, st);
    step(1'b1, 1'b0, 32'd40, 32'd3, st);
    load_wait(32'd40, d);
    chk("last_wins_immediate", d, 32'd3);
    idle(WD + 1);
    load_wait(32'd40, d);
    chk("last_wins_drained", d, 32'd3);

    // Reset with buffered stores discards them; array keeps old data
    idle(WD + 1);
    step(1'b1, 1'b1, 32'd200, 32'h1111_1111, st);
    step(1'b1, 1'b1, 32'd204, 32'h2222_2222, st);
    step(1'b1, 1'b1, 32'd208, 32'h3333_3333, st);
    chk("pre_reset_count", 32'(u_dut.u_wbuf.count), 32'd3);
    do_reset();
    load_wait(32'd200, d);
    chk("reset_discard_200", d, 32'hA000_0032);

    // Randomized traffic over a few words so buffer hits are frequent
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        a = $urandom;
        a[7:2] = 6'($urandom_range(0, 7));
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, st);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
